// File: rtl/pipe_hazard_ctrl_if.sv
// Interface bundling the ID-stage hazard inputs and the controller's
// stall/flush/forward outputs for pipe_hazard_ctrl.
// Handshake: no valid/ready pair here. id_valid qualifies the ID fields in
// the same cycle; stall and flush_id are combinational answers for that
// cycle; fwd_sel_* are registered and describe the instruction now in EX.
interface pipe_hazard_ctrl_if #(
    parameter int RF_SIZE = 5,
    parameter int N_SLOTS = 3
);
    localparam int SEL_W = $clog2(N_SLOTS + 1);

    logic               id_valid;
    logic [RF_SIZE-1:0] id_rs1;
    logic [RF_SIZE-1:0] id_rs2;
    logic               id_rs1_used;
    logic               id_rs2_used;
    logic [RF_SIZE-1:0] id_rd;
    logic               id_reg_write;
    logic               id_mem_re;
    logic               ex_redirect;
    logic               stall;
    logic               flush_id;
    logic [SEL_W-1:0]   fwd_sel_a_ex;
    logic [SEL_W-1:0]   fwd_sel_b_ex;
    logic [31:0]        perf_stalls;
    logic [31:0]        perf_flushes;

    // Pipeline side: presents the ID instruction, consumes hazard decisions.
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_mem_re, ex_redirect,
        input  stall, flush_id, fwd_sel_a_ex, fwd_sel_b_ex,
               perf_stalls, perf_flushes
    );

    // Controller side.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_mem_re, ex_redirect,
        output stall, flush_id, fwd_sel_a_ex, fwd_sel_b_ex,
               perf_stalls, perf_flushes
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for an IF/ID/EX/MEM/WB style pipeline.
// A scoreboard shift register follows every instruction past ID
// (slot0=EX ... slot N_SLOTS-1=WB). From it the block derives the load-use
// stall, the ID flush on an EX redirect, and registered forward selects.
// Optional stall/flush counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int RF_SIZE  = 5,
    parameter int N_SLOTS  = 3,
    parameter int LOAD_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int SEL_W = $clog2(N_SLOTS + 1);

    // Scoreboard: one entry per post-ID stage, index 0 is the youngest.
    logic               slot_valid_q [N_SLOTS];
    logic [RF_SIZE-1:0] slot_rd_q    [N_SLOTS];
    logic               slot_wr_q    [N_SLOTS];
    logic               slot_ld_q    [N_SLOTS];

    logic               a_hit, b_hit;
    logic               a_ld, b_ld;
    int                 a_m, b_m;
    logic               stall_w;
    logic               enter_w;
    logic [SEL_W-1:0]   fwd_a_d, fwd_b_d;
    logic [SEL_W-1:0]   fwd_a_q, fwd_b_q;

    // Find the youngest producing slot for each used source. Scanning from
    // the oldest slot down lets the lowest index overwrite older matches.
    always_comb begin
        a_hit = 1'b0;
        a_ld  = 1'b0;
        a_m   = 0;
        b_hit = 1'b0;
        b_ld  = 1'b0;
        b_m   = 0;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            if (slot_valid_q[k] && slot_wr_q[k] && hz.id_rs1_used &&
                (hz.id_rs1 != '0) && (slot_rd_q[k] == hz.id_rs1)) begin
                a_hit = 1'b1;
                a_ld  = slot_ld_q[k];
                a_m   = k;
            end
            if (slot_valid_q[k] && slot_wr_q[k] && hz.id_rs2_used &&
                (hz.id_rs2 != '0) && (slot_rd_q[k] == hz.id_rs2)) begin
                b_hit = 1'b1;
                b_ld  = slot_ld_q[k];
                b_m   = k;
            end
        end
    end

    // Load-use stall unless a redirect is discarding the ID instruction;
    // then decide whether ID moves into slot0 and what EX will forward.
    always_comb begin
        stall_w = hz.id_valid && !hz.ex_redirect &&
                  ((a_hit && a_ld && (a_m < LOAD_LAT)) ||
                   (b_hit && b_ld && (b_m < LOAD_LAT)));
        enter_w = hz.id_valid && !stall_w && !hz.ex_redirect;
        fwd_a_d = '0;
        fwd_b_d = '0;
        // A producer in the last slot writes the RF on this edge, so ID/EX
        // already captures the right value and no forward is needed.
        if (enter_w && a_hit && (a_m < N_SLOTS - 1)) begin
            fwd_a_d = SEL_W'(a_m + 1);
        end
        if (enter_w && b_hit && (b_m < N_SLOTS - 1)) begin
            fwd_b_d = SEL_W'(b_m + 1);
        end
    end

    assign hz.stall        = stall_w;
    assign hz.flush_id     = hz.ex_redirect;
    assign hz.fwd_sel_a_ex = fwd_a_q;
    assign hz.fwd_sel_b_ex = fwd_b_q;

    // Advance the scoreboard every cycle; the back end never stalls, so a
    // held or flushed ID instruction becomes a bubble in slot0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_SLOTS; k++) begin
                slot_valid_q[k] <= 1'b0;
                slot_rd_q[k]    <= '0;
                slot_wr_q[k]    <= 1'b0;
                slot_ld_q[k]    <= 1'b0;
            end
        end else begin
            for (int k = 1; k < N_SLOTS; k++) begin
                slot_valid_q[k] <= slot_valid_q[k-1];
                slot_rd_q[k]    <= slot_rd_q[k-1];
                slot_wr_q[k]    <= slot_wr_q[k-1];
                slot_ld_q[k]    <= slot_ld_q[k-1];
            end
            slot_valid_q[0] <= enter_w;
            slot_rd_q[0]    <= hz.id_rd;
            slot_wr_q[0]    <= hz.id_reg_write;
            slot_ld_q[0]    <= hz.id_mem_re;
        end
    end

    // Forward selects for the instruction entering EX (zero for bubbles).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_q <= '0;
            fwd_b_q <= '0;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stalls_q,  perf_stalls_d;
    logic [31:0] perf_flushes_q, perf_flushes_d;

    // Saturating event counters.
    always_comb begin
        perf_stalls_d  = perf_stalls_q;
        perf_flushes_d = perf_flushes_q;
        if (stall_w && (perf_stalls_q != 32'hFFFF_FFFF)) begin
            perf_stalls_d = perf_stalls_q + 32'd1;
        end
        if (hz.ex_redirect && (perf_flushes_q != 32'hFFFF_FFFF)) begin
            perf_flushes_d = perf_flushes_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stalls_q  <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_stalls_q  <= perf_stalls_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign hz.perf_stalls  = perf_stalls_q;
    assign hz.perf_flushes = perf_flushes_q;
`else
    assign hz.perf_stalls  = '0;
    assign hz.perf_flushes = '0;
`endif
endmodule
